// File: rtl/frame_buf_pkg.sv
// Shared types for the triple-buffer frame scheduler: slot states, FSM
// encodings and slot address arithmetic.
package frame_buf_pkg;

    localparam int NUM_SLOT = 3;
    localparam int IDX_W    = 2;
    localparam int ADDR_W   = 24;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_st_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_LOAD   = 2'd1,
        W_ACTIVE = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_LOAD   = 2'd1,
        R_ACTIVE = 2'd2
    } r_state_t;

    // Address wraps modulo 2^24 by construction of the 24-bit result.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0]  idx,
                                                    input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] stride);
        logic [ADDR_W-1:0] prod;
        prod = ADDR_W'(idx) * stride;
        return base + prod;
    endfunction

endpackage

// File: rtl/frame_buf_sched_if.sv
// Producer/display/sdram_mcb handshake bundle of the frame scheduler.
interface frame_buf_sched_if;
    import frame_buf_pkg::*;

    logic              mem_rdy;
    logic              wr_frame_req;
    logic              wr_load;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_busy;
    logic              wr_done;
    logic              rd_frame_req;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_busy;
    logic              rd_done;
    logic              rd_repeat;
    logic [IDX_W-1:0]  rd_idx;
    logic [15:0]       drop_cnt;

    modport master (
        output mem_rdy, wr_frame_req, wr_done, rd_frame_req, rd_done,
        input  wr_load, wr_addr, wr_busy, rd_load, rd_addr, rd_busy,
               rd_repeat, rd_idx, drop_cnt
    );

    modport slave (
        input  mem_rdy, wr_frame_req, wr_done, rd_frame_req, rd_done,
        output wr_load, wr_addr, wr_busy, rd_load, rd_addr, rd_busy,
               rd_repeat, rd_idx, drop_cnt
    );

endinterface

// File: rtl/fb_slot_pick.sv
// Combinational slot selection: which slot the writer claims next, which slot
// the reader shows next, and which slot is currently being displayed.
module fb_slot_pick
    import frame_buf_pkg::*;
(
    input  logic [2*NUM_SLOT-1:0] slot_vec_i,
    input  logic [IDX_W-1:0]      newest_idx_i,
    input  logic                  newest_vld_i,
    output logic                  wr_vld_o,
    output logic [IDX_W-1:0]      wr_idx_o,
    output logic                  wr_drop_o,
    output logic                  rd_vld_o,
    output logic [IDX_W-1:0]      rd_idx_o,
    output logic                  rd_repeat_o,
    output logic                  cur_vld_o,
    output logic [IDX_W-1:0]      cur_idx_o
);

    logic [NUM_SLOT-1:0] is_free;
    logic [NUM_SLOT-1:0] is_stale;
    logic [NUM_SLOT-1:0] is_reading;

    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_flag
        slot_st_t st;
        assign st             = slot_st_t'(slot_vec_i[2*gi +: 2]);
        assign is_free[gi]    = (st == SLOT_FREE);
        assign is_stale[gi]   = (st == SLOT_READY) &&
                                !(newest_vld_i && (newest_idx_i == IDX_W'(gi)));
        assign is_reading[gi] = (st == SLOT_READING);
    end

    logic                 free_vld;
    logic [IDX_W-1:0]     free_idx;
    logic                 stale_vld;
    logic [IDX_W-1:0]     stale_idx;

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        free_vld  = 1'b0;
        free_idx  = '0;
        stale_vld = 1'b0;
        stale_idx = '0;
        cur_vld_o = 1'b0;
        cur_idx_o = '0;
        for (int i = NUM_SLOT - 1; i >= 0; i--) begin
            if (is_free[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (is_stale[i]) begin
                stale_vld = 1'b1;
                stale_idx = IDX_W'(i);
            end
            if (is_reading[i]) begin
                cur_vld_o = 1'b1;
                cur_idx_o = IDX_W'(i);
            end
        end

        wr_vld_o    = free_vld || stale_vld;
        wr_idx_o    = free_vld ? free_idx : stale_idx;
        wr_drop_o   = !free_vld && stale_vld;

        rd_vld_o    = newest_vld_i || cur_vld_o;
        rd_idx_o    = newest_vld_i ? newest_idx_i : cur_idx_o;
        rd_repeat_o = !newest_vld_i && cur_vld_o;
    end

endmodule

// File: rtl/frame_buf_sched.sv
// Triple-buffer frame scheduler: hands the producer a free SDRAM slot per frame
// and always gives the display the newest complete frame (or repeats the last).
module frame_buf_sched
    import frame_buf_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h100000,
    parameter int unsigned       LOAD_CYC   = 4
) (
    input  logic                    clk_sdram,
    input  logic                    rst_n,
    frame_buf_sched_if.slave        bus
);

    localparam int              CNT_W    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_CYC - 1);

    w_state_t          w_state_q,   w_state_d;
    r_state_t          r_state_q,   r_state_d;
    logic              wr_pend_q,   wr_pend_d;
    logic              rd_pend_q,   rd_pend_d;
    logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
    logic [IDX_W-1:0]  wr_idx_q,    wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q,    rd_idx_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic              rd_repeat_q, rd_repeat_d;
    logic [IDX_W-1:0]  newest_idx_q, newest_idx_d;
    logic              newest_vld_q, newest_vld_d;
    logic [15:0]       drop_cnt_q,  drop_cnt_d;

    logic [2*NUM_SLOT-1:0] slot_vec;

    logic             pick_wr_vld, pick_wr_drop, pick_rd_vld, pick_rd_repeat, pick_cur_vld;
    logic [IDX_W-1:0] pick_wr_idx, pick_rd_idx, pick_cur_idx;

    logic rd_decide, rd_take, rd_release;
    logic wr_claim, wr_finish, wr_evict, drop_inc;

    fb_slot_pick u_pick (
        .slot_vec_i   (slot_vec),
        .newest_idx_i (newest_idx_q),
        .newest_vld_i (newest_vld_q),
        .wr_vld_o     (pick_wr_vld),
        .wr_idx_o     (pick_wr_idx),
        .wr_drop_o    (pick_wr_drop),
        .rd_vld_o     (pick_rd_vld),
        .rd_idx_o     (pick_rd_idx),
        .rd_repeat_o  (pick_rd_repeat),
        .cur_vld_o    (pick_cur_vld),
        .cur_idx_o    (pick_cur_idx)
    );

    // Reader FSM; its decision cycle takes priority over the writer's.
    always_comb begin
        r_state_d   = r_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_addr_d   = rd_addr_q;
        rd_repeat_d = rd_repeat_q;
        rd_pend_d   = rd_pend_q | bus.rd_frame_req;
        rd_decide   = 1'b0;
        rd_take     = 1'b0;
        rd_release  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (rd_pend_q && bus.mem_rdy) begin
                    rd_decide = 1'b1;
                    rd_pend_d = 1'b0;
                    if (pick_rd_vld) begin
                        r_state_d   = R_LOAD;
                        rd_cnt_d    = '0;
                        rd_idx_d    = pick_rd_idx;
                        rd_addr_d   = slot_addr(pick_rd_idx, BASE_ADDR, BUF_STRIDE);
                        rd_repeat_d = pick_rd_repeat;
                        rd_take     = !pick_rd_repeat;
                        rd_release  = !pick_rd_repeat && pick_cur_vld;
                    end
                end
            end
            R_LOAD: begin
                if (rd_cnt_q == CNT_LAST) r_state_d = R_ACTIVE;
                else                      rd_cnt_d  = rd_cnt_q + CNT_W'(1);
            end
            R_ACTIVE: begin
                if (bus.rd_done) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        wr_cnt_d  = wr_cnt_q;
        wr_idx_d  = wr_idx_q;
        wr_addr_d = wr_addr_q;
        wr_pend_d = wr_pend_q | bus.wr_frame_req;
        wr_claim  = 1'b0;
        wr_finish = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_pend_q && bus.mem_rdy && !rd_decide && pick_wr_vld) begin
                    wr_claim  = 1'b1;
                    wr_pend_d = 1'b0;
                    w_state_d = W_LOAD;
                    wr_cnt_d  = '0;
                    wr_idx_d  = pick_wr_idx;
                    wr_addr_d = slot_addr(pick_wr_idx, BASE_ADDR, BUF_STRIDE);
                end
            end
            W_LOAD: begin
                if (wr_cnt_q == CNT_LAST) w_state_d = W_ACTIVE;
                else                      wr_cnt_d  = wr_cnt_q + CNT_W'(1);
            end
            W_ACTIVE: begin
                if (bus.wr_done) begin
                    wr_finish = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // newest_vld implies that slot is READY unless the reader grabs it this cycle.
    always_comb begin
        wr_evict     = wr_finish && newest_vld_q && !rd_take;
        drop_inc     = (wr_claim && pick_wr_drop) || wr_evict;
        newest_idx_d = newest_idx_q;
        newest_vld_d = newest_vld_q;
        if (rd_take) newest_vld_d = 1'b0;
        if (wr_finish) begin
            newest_idx_d = wr_idx_q;
            newest_vld_d = 1'b1;
        end
        drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
        localparam logic [IDX_W-1:0] GI = IDX_W'(gi);
        slot_st_t st_q, st_d;

        always_comb begin
            st_d = st_q;
            if (rd_release && (pick_cur_idx == GI)) st_d = SLOT_FREE;
            if (rd_take    && (newest_idx_q == GI)) st_d = SLOT_READING;
            if (wr_claim   && (pick_wr_idx  == GI)) st_d = SLOT_WRITING;
            if (wr_finish  && (wr_idx_q     == GI)) st_d = SLOT_READY;
            if (wr_evict   && (newest_idx_q == GI)) st_d = SLOT_FREE;
        end

        always_ff @(posedge clk_sdram or negedge rst_n) begin
            if (!rst_n) st_q <= SLOT_FREE;
            else        st_q <= st_d;
        end

        assign slot_vec[2*gi +: 2] = st_q;
    end

    always_ff @(posedge clk_sdram or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_repeat_q  <= 1'b0;
            newest_idx_q <= '0;
            newest_vld_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_repeat_q  <= rd_repeat_d;
            newest_idx_q <= newest_idx_d;
            newest_vld_q <= newest_vld_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.wr_load   = (w_state_q == W_LOAD);
    assign bus.wr_busy   = (w_state_q != W_IDLE);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_load   = (r_state_q == R_LOAD);
    assign bus.rd_busy   = (r_state_q != R_IDLE);
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_repeat = rd_repeat_q;
    assign bus.rd_idx    = rd_idx_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched: expected load events are queued with
// the stimulus and matched against load pulses captured by a monitor.
`timescale 1ns/1ps
module tb_frame_buf_sched;
    import frame_buf_pkg::*;

    localparam int LOAD_CYC = 4;

    logic clk_sdram = 1'b0;
    logic rst_n     = 1'b0;

    frame_buf_sched_if fb_if();

    frame_buf_sched #(
        .BASE_ADDR  (24'h000000),
        .BUF_STRIDE (24'h100000),
        .LOAD_CYC   (LOAD_CYC)
    ) dut (
        .clk_sdram (clk_sdram),
        .rst_n     (rst_n),
        .bus       (fb_if)
    );

    always #5 clk_sdram = ~clk_sdram;

    typedef struct packed {
        logic        is_rd;
        logic [23:0] addr;
        logic        rep;
        logic [1:0]  idx;
        logic [7:0]  width;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  rise_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  saw_rd_busy = 1'b0;

    always @(posedge clk_sdram) cyc <= cyc + 1;

    // Monitor: one event per load pulse, recorded when the strobe falls.
    int wr_w = 0, rd_w = 0, wr_rise = 0, rd_rise = 0;
    always @(negedge clk_sdram) begin
        ev_t ev;
        if (fb_if.rd_busy === 1'b1) saw_rd_busy = 1'b1;
        if (fb_if.wr_load === 1'b1) begin
            if (wr_w == 0) wr_rise = cyc;
            wr_w++;
        end else if (wr_w != 0) begin
            ev = '{is_rd: 1'b0, addr: fb_if.wr_addr, rep: 1'b0, idx: 2'd0, width: 8'(wr_w)};
            obs_q.push_back(ev);
            rise_q.push_back(wr_rise);
            wr_w = 0;
        end
        if (fb_if.rd_load === 1'b1) begin
            if (rd_w == 0) rd_rise = cyc;
            rd_w++;
        end else if (rd_w != 0) begin
            ev = '{is_rd: 1'b1, addr: fb_if.rd_addr, rep: fb_if.rd_repeat, idx: fb_if.rd_idx,
                   width: 8'(rd_w)};
            obs_q.push_back(ev);
            rise_q.push_back(rd_rise);
            rd_w = 0;
        end
    end

    function automatic ev_t mk(input logic is_rd, input logic [23:0] a,
                               input logic rep, input logic [1:0] idx);
        ev_t e;
        e.is_rd = is_rd;
        e.addr  = a;
        e.rep   = rep;
        e.idx   = idx;
        e.width = 8'(LOAD_CYC);
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sdram);
    endtask

    // m = {rd_done, wr_done, rd_frame_req, wr_frame_req}, held for one cycle.
    task automatic pulse(input logic [3:0] m);
        @(negedge clk_sdram);
        {fb_if.rd_done, fb_if.wr_done, fb_if.rd_frame_req, fb_if.wr_frame_req} = m;
        @(negedge clk_sdram);
        {fb_if.rd_done, fb_if.wr_done, fb_if.rd_frame_req, fb_if.wr_frame_req} = 4'b0000;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sdram);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({fb_if.wr_load, fb_if.rd_load, fb_if.wr_busy, fb_if.rd_busy, fb_if.rd_repeat} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {fb_if.wr_load, fb_if.rd_load, fb_if.wr_busy, fb_if.rd_busy, fb_if.rd_repeat});
        end
        checks++;
        if (fb_if.wr_addr !== 24'h0) begin
            failures++; $display("FAIL reset_wr_addr got=%h exp=000000", fb_if.wr_addr);
        end
        checks++;
        if (fb_if.rd_addr !== 24'h0) begin
            failures++; $display("FAIL reset_rd_addr got=%h exp=000000", fb_if.rd_addr);
        end
        checks++;
        if (fb_if.rd_idx !== 2'd0) begin
            failures++; $display("FAIL reset_rd_idx got=%0d exp=0", fb_if.rd_idx);
        end
        checks++;
        if (fb_if.drop_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", fb_if.drop_cnt);
        end
        rst_n = 1'b1;
        tick(2);
        $display("reset: outputs idle");
    endtask

    task automatic test_first_write();
        ev_t e, o;
        bit  ok;
        int  r;
        exp_q.push_back(mk(1'b0, 24'h000000, 1'b0, 2'd0));
        pulse(4'b0001);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL first_write_event got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL first_write_load got=%h exp=%h", o, e); end
            $display("first_write: wr addr=%h width=%0d rise=%0d", o.addr, o.width, r);
        end
        exp_q.delete();
        checks++;
        if (fb_if.wr_busy !== 1'b1) begin failures++; $display("FAIL first_write_busy got=%b exp=1", fb_if.wr_busy); end
        pulse(4'b0100);
        checks++;
        if (fb_if.wr_busy !== 1'b0) begin failures++; $display("FAIL first_write_idle got=%b exp=0", fb_if.wr_busy); end
    endtask

    task automatic test_read_repeat();
        ev_t e, o;
        bit  ok;
        int  r;
        ev_t tbl [2];
        tbl[0] = mk(1'b1, 24'h000000, 1'b0, 2'd0);
        tbl[1] = mk(1'b1, 24'h000000, 1'b1, 2'd0);
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(tbl[s]);
            pulse(4'b0010);
            wait_obs(1, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL read_event%0d got=%0d exp=1", s, obs_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
                checks++;
                if (o !== e) begin failures++; $display("FAIL read_load%0d got=%h exp=%h", s, o, e); end
                $display("read%0d: rd addr=%h rep=%0b idx=%0d width=%0d", s, o.addr, o.rep, o.idx, o.width);
            end
            exp_q.delete();
            checks++;
            if (fb_if.rd_busy !== 1'b1) begin failures++; $display("FAIL read_busy%0d got=%b exp=1", s, fb_if.rd_busy); end
            pulse(4'b1000);
        end
        checks++;
        if (fb_if.rd_busy !== 1'b0) begin failures++; $display("FAIL read_idle got=%b exp=0", fb_if.rd_busy); end
    endtask

    task automatic test_drop();
        ev_t e, o;
        bit  ok;
        int  r;
        ev_t        tbl  [3];
        logic [3:0] req  [3];
        logic [3:0] done [3];
        tbl[0] = mk(1'b0, 24'h100000, 1'b0, 2'd0); req[0] = 4'b0001; done[0] = 4'b0100;
        tbl[1] = mk(1'b0, 24'h200000, 1'b0, 2'd0); req[1] = 4'b0001; done[1] = 4'b0100;
        tbl[2] = mk(1'b1, 24'h200000, 1'b0, 2'd2); req[2] = 4'b0010; done[2] = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(tbl[s]);
            pulse(req[s]);
            wait_obs(1, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL drop_event%0d got=%0d exp=1", s, obs_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
                checks++;
                if (o !== e) begin failures++; $display("FAIL drop_load%0d got=%h exp=%h", s, o, e); end
                $display("drop%0d: %s addr=%h rep=%0b idx=%0d width=%0d", s, o.is_rd ? "rd" : "wr",
                         o.addr, o.rep, o.idx, o.width);
            end
            exp_q.delete();
            pulse(done[s]);
            if (s == 1) begin
                checks++;
                if (fb_if.drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", fb_if.drop_cnt); end
            end
        end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        bit  ok;
        int  r, d;
        // Slot 2 is being read, slots 0/1 free: the new frame goes to slot 0.
        exp_q.push_back(mk(1'b0, 24'h000000, 1'b0, 2'd0));
        pulse(4'b0001);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL simul_pre_event got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL simul_pre_load got=%h exp=%h", o, e); end
            $display("simul_pre: wr addr=%h width=%0d", o.addr, o.width);
        end
        exp_q.delete();
        pulse(4'b0100);

        exp_q.push_back(mk(1'b1, 24'h000000, 1'b0, 2'd0));
        exp_q.push_back(mk(1'b0, 24'h100000, 1'b0, 2'd0));
        pulse(4'b0011);
        wait_obs(2, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL simul_events got=%0d exp=2", obs_q.size()); end
        d = (rise_q.size() >= 2) ? (rise_q[1] - rise_q[0]) : -99;
        checks++;
        if (d !== 1) begin failures++; $display("FAIL simul_rise_gap got=%0d exp=1", d); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL simul_load got=%h exp=%h", o, e); end
            $display("simul: %s addr=%h rep=%0b idx=%0d rise=%0d", o.is_rd ? "rd" : "wr",
                     o.addr, o.rep, o.idx, r);
        end
        exp_q.delete();
        pulse(4'b0100);
        pulse(4'b1000);
        checks++;
        if (fb_if.drop_cnt !== 16'd1) begin failures++; $display("FAIL simul_drop_cnt got=%0d exp=1", fb_if.drop_cnt); end
    endtask

    task automatic test_no_frame_mem_rdy();
        ev_t e, o;
        bit  ok;
        int  r;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        obs_q.delete(); rise_q.delete();
        saw_rd_busy = 1'b0;
        pulse(4'b0010);
        tick(20);
        checks++;
        if (obs_q.size() != 0 || saw_rd_busy) begin
            failures++;
            $display("FAIL empty_read got=%0d events busy=%b exp=0 events busy=0", obs_q.size(), saw_rd_busy);
        end
        $display("empty_read: no load issued");

        @(negedge clk_sdram);
        fb_if.mem_rdy = 1'b0;
        pulse(4'b0001);
        tick(15);
        checks++;
        if (obs_q.size() != 0 || fb_if.wr_busy !== 1'b0) begin
            failures++;
            $display("FAIL mem_rdy_hold got=%0d events busy=%b exp=0 events busy=0", obs_q.size(), fb_if.wr_busy);
        end
        exp_q.push_back(mk(1'b0, 24'h000000, 1'b0, 2'd0));
        fb_if.mem_rdy = 1'b1;
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mem_rdy_event got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL mem_rdy_load got=%h exp=%h", o, e); end
            $display("mem_rdy: wr addr=%h width=%0d", o.addr, o.width);
        end
        exp_q.delete();
        pulse(4'b0100);
        tick(15);
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL stale_read_pend got=%0d events exp=0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        ev_t e, o;
        bit  ok;
        int  r;
        exp_q.push_back(mk(1'b0, 24'h100000, 1'b0, 2'd0));
        pulse(4'b0001);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_pre_event got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL midrst_pre_load got=%h exp=%h", o, e); end
            $display("midrst_pre: wr addr=%h width=%0d", o.addr, o.width);
        end
        exp_q.delete();
        pulse(4'b0100);
        checks++;
        if (fb_if.drop_cnt !== 16'd1) begin failures++; $display("FAIL midrst_drop_pre got=%0d exp=1", fb_if.drop_cnt); end

        pulse(4'b0001);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fb_if.wr_load === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk_sdram);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_load_seen got=%b exp=1", fb_if.wr_load); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_if.wr_load, fb_if.wr_busy, fb_if.drop_cnt} !== 18'd0) begin
            failures++;
            $display("FAIL midrst_clear got=load%b busy%b drop%0d exp=load0 busy0 drop0",
                     fb_if.wr_load, fb_if.wr_busy, fb_if.drop_cnt);
        end
        $display("midrst: reset asserted during wr_load");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        obs_q.delete(); rise_q.delete();

        pulse(4'b0010);
        tick(15);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_no_read got=%0d events exp=0", obs_q.size()); end

        exp_q.push_back(mk(1'b0, 24'h000000, 1'b0, 2'd0));
        pulse(4'b0001);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_post_event got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rise_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL midrst_post_load got=%h exp=%h", o, e); end
            $display("midrst_post: wr addr=%h width=%0d", o.addr, o.width);
        end
        exp_q.delete();
        pulse(4'b0100);
    endtask

    initial begin
        fb_if.mem_rdy      = 1'b1;
        fb_if.wr_frame_req = 1'b0;
        fb_if.wr_done      = 1'b0;
        fb_if.rd_frame_req = 1'b0;
        fb_if.rd_done      = 1'b0;
        test_reset();
        test_first_write();
        test_read_repeat();
        test_drop();
        test_simultaneous();
        test_no_frame_mem_rdy();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
